// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port line memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEFAULT_DATA_W = 256;
    localparam int unsigned DEFAULT_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side line buses of the arbiter, bundled for port passing.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
);

    logic              m0_enable_i;
    logic              m0_write_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_data_i;
    logic              m0_ack_o;
    logic [DATA_W-1:0] m0_data_o;

    logic              m1_enable_i;
    logic              m1_write_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_data_i;
    logic              m1_ack_o;
    logic [DATA_W-1:0] m1_data_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;

    logic [1:0]        grant_o;

    // Arbiter side
    modport slave (
        input  m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
        input  m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
        input  mem_ack_i, mem_data_i,
        output m0_ack_o, m0_data_o, m1_ack_o, m1_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, grant_o
    );

    // Environment side (requesters and memory)
    modport master (
        output m0_enable_i, m0_write_i, m0_addr_i, m0_data_i,
        output m1_enable_i, m1_write_i, m1_addr_i, m1_data_i,
        output mem_ack_i, mem_data_i,
        input  m0_ack_o, m0_data_o, m1_ack_o, m1_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o, grant_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick; on a tie the port that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt_c
);

    always_comb begin
        gnt_c = 2'b00;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = last_grant ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-based memory port between the instruction and data caches,
// one whole line transaction at a time, round-robin on contention.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus
);

    state_t            state;
    logic              last_grant;
    logic [1:0]        pick_c;
    logic [1:0]        grant_q;
    logic              mem_enable_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;

    rr_arb2 u_rr_arb2 (
        .req        ({bus.m1_enable_i, bus.m0_enable_i}),
        .last_grant (last_grant),
        .gnt_c      (pick_c)
    );

    // Arbitration only happens in IDLE; the winner's request is captured at the grant edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_q      <= 2'b00;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_enable_q <= 1'b0;
                    if (pick_c[0]) begin
                        state        <= BUSY0;
                        last_grant   <= 1'b0;
                        grant_q      <= 2'b01;
                        mem_enable_q <= 1'b1;
                        mem_write_q  <= bus.m0_write_i;
                        mem_addr_q   <= bus.m0_addr_i;
                        mem_data_q   <= bus.m0_data_i;
                    end else if (pick_c[1]) begin
                        state        <= BUSY1;
                        last_grant   <= 1'b1;
                        grant_q      <= 2'b10;
                        mem_enable_q <= 1'b1;
                        mem_write_q  <= bus.m1_write_i;
                        mem_addr_q   <= bus.m1_addr_i;
                        mem_data_q   <= bus.m1_data_i;
                    end
                end
                BUSY0, BUSY1: begin
                    // Always return through IDLE so a finishing requester's stale enable is not regranted
                    if (bus.mem_ack_i) begin
                        state        <= IDLE;
                        grant_q      <= 2'b00;
                        mem_enable_q <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    grant_q      <= 2'b00;
                    mem_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign bus.grant_o      = grant_q;

    // Read data is broadcast; only the owner's ack qualifies it
    assign bus.m0_ack_o  = (state == BUSY0) && bus.mem_ack_i;
    assign bus.m1_ack_o  = (state == BUSY1) && bus.mem_ack_i;
    assign bus.m0_data_o = bus.mem_data_i;
    assign bus.m1_data_o = bus.mem_data_i;

endmodule
